// File: rtl/e_mdu_pkg.sv
// rtl/e_mdu_pkg.sv - shared MDU opcodes, FSM state type and opcode classifiers
package e_mdu_pkg;

  localparam logic [7:0] MDU_MULT  = 8'd32;
  localparam logic [7:0] MDU_MULTU = 8'd33;
  localparam logic [7:0] MDU_DIV   = 8'd34;
  localparam logic [7:0] MDU_DIVU  = 8'd35;
  localparam logic [7:0] MDU_MFHI  = 8'd36;
  localparam logic [7:0] MDU_MFLO  = 8'd37;
  localparam logic [7:0] MDU_MTHI  = 8'd38;
  localparam logic [7:0] MDU_MTLO  = 8'd39;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } mdu_state_e;

  // Ops that occupy the unit for several cycles and raise busy.
  function automatic logic is_multicycle_op(input logic [7:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  function automatic logic is_mult_op(input logic [7:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU);
  endfunction

endpackage

// File: rtl/e_mdu_if.sv
// rtl/e_mdu_if.sv - E-stage to MDU operand/result bundle
interface e_mdu_if;

  logic        IntReq;
  logic [7:0]  E_ALUop_i;
  logic [31:0] E_rsValue_i;
  logic [31:0] E_rtValue_i;
  logic        mdu_start_o;
  logic        mdu_busy_o;
  logic [31:0] mdu_hi_o;
  logic [31:0] mdu_lo_o;
  logic [31:0] mdu_rd_o;

  modport master (
    output IntReq, E_ALUop_i, E_rsValue_i, E_rtValue_i,
    input  mdu_start_o, mdu_busy_o, mdu_hi_o, mdu_lo_o, mdu_rd_o
  );

  modport slave (
    input  IntReq, E_ALUop_i, E_rsValue_i, E_rtValue_i,
    output mdu_start_o, mdu_busy_o, mdu_hi_o, mdu_lo_o, mdu_rd_o
  );

endinterface

// File: rtl/e_mdu_calc.sv
// rtl/e_mdu_calc.sv - combinational 64-bit mult/div result, {HI,LO} passthrough otherwise
module e_mdu_calc
  import e_mdu_pkg::*;
(
  input  logic [7:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        div_signed;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] b_safe;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quot;
  logic [31:0] rem;

  assign prod_s = $signed({{32{rs[31]}}, rs}) * $signed({{32{rt[31]}}, rt});
  assign prod_u = {32'd0, rs} * {32'd0, rt};

  // Signed divide runs on magnitudes; 0x80000000 has the same magnitude bits unsigned,
  // so the -2^31 / -1 case lands on quotient 0x80000000, remainder 0 with no special path.
  assign div_signed = (op == MDU_DIV);
  assign a_neg      = div_signed & rs[31];
  assign b_neg      = div_signed & rt[31];
  assign a_mag      = a_neg ? (~rs + 32'd1) : rs;
  assign b_mag      = b_neg ? (~rt + 32'd1) : rt;
  assign b_safe     = (rt == 32'd0) ? 32'd1 : b_mag;
  assign q_mag      = a_mag / b_safe;
  assign r_mag      = a_mag % b_safe;
  assign quot       = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
  assign rem        = a_neg ? (~r_mag + 32'd1) : r_mag;

  always_comb begin
    res_hi = hi;
    res_lo = lo;
    case (op)
      MDU_MULT:  {res_hi, res_lo} = prod_s;
      MDU_MULTU: {res_hi, res_lo} = prod_u;
      MDU_DIV, MDU_DIVU: begin
        if (rt != 32'd0) begin
          res_hi = rem;
          res_lo = quot;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/e_mdu.sv
// rtl/e_mdu.sv - multiply/divide unit with HI/LO, multi-cycle busy and mfhi/mflo readout
module e_mdu
  import e_mdu_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic    clk,
  input  logic    reset,
  e_mdu_if.slave  mdu
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES) + 1;
  localparam logic [CW-1:0] N_MULT = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] N_DIV  = CW'(DIV_CYCLES);

  mdu_state_e    state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          busy, busy_nx;
  logic [31:0]   hi, hi_nx;
  logic [31:0]   lo, lo_nx;
  logic [31:0]   pend_hi, pend_hi_nx;
  logic [31:0]   pend_lo, pend_lo_nx;
  logic [31:0]   calc_hi, calc_lo;
  logic          start;

  e_mdu_calc u_calc (
    .op     (mdu.E_ALUop_i),
    .rs     (mdu.E_rsValue_i),
    .rt     (mdu.E_rtValue_i),
    .hi     (hi),
    .lo     (lo),
    .res_hi (calc_hi),
    .res_lo (calc_lo)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      busy    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      busy    <= busy_nx;
      hi      <= hi_nx;
      lo      <= lo_nx;
      pend_hi <= pend_hi_nx;
      pend_lo <= pend_lo_nx;
    end
  end

  // IntReq only gates new work; an op already in RUN was committed before the flush.
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    busy_nx    = busy;
    hi_nx      = hi;
    lo_nx      = lo;
    pend_hi_nx = pend_hi;
    pend_lo_nx = pend_lo;
    case (state)
      IDLE: begin
        if (start && !busy) begin
          pend_hi_nx = calc_hi;
          pend_lo_nx = calc_lo;
          cnt_nx     = is_mult_op(mdu.E_ALUop_i) ? N_MULT : N_DIV;
          busy_nx    = 1'b1;
          state_nx   = RUN;
        end else if (!busy && !mdu.IntReq) begin
          if (mdu.E_ALUop_i == MDU_MTHI) hi_nx = mdu.E_rsValue_i;
          if (mdu.E_ALUop_i == MDU_MTLO) lo_nx = mdu.E_rsValue_i;
        end
      end
      RUN: begin
        if (cnt == CW'(1)) begin
          hi_nx    = pend_hi;
          lo_nx    = pend_lo;
          busy_nx  = 1'b0;
          cnt_nx   = '0;
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt - CW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    start = is_multicycle_op(mdu.E_ALUop_i) && !mdu.IntReq;
    case (mdu.E_ALUop_i)
      MDU_MFHI: mdu.mdu_rd_o = hi;
      MDU_MFLO: mdu.mdu_rd_o = lo;
      default:  mdu.mdu_rd_o = 32'd0;
    endcase
  end

  assign mdu.mdu_start_o = start;
  assign mdu.mdu_busy_o  = busy;
  assign mdu.mdu_hi_o    = hi;
  assign mdu.mdu_lo_o    = lo;

endmodule

// File: tb/tb_e_mdu.sv
// tb/tb_e_mdu.sv - table-driven, hand-sequenced and randomized checks of e_mdu
module tb_e_mdu;
  import e_mdu_pkg::*;

  localparam int MULT_CYCLES = 5;
  localparam int DIV_CYCLES  = 10;
  localparam logic [7:0] NOP = 8'd43;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int vectors = 0;
  int miscompares = 0;
  logic [31:0] m_hi, m_lo;

  e_mdu_if mif ();

  e_mdu #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)) dut (
    .clk   (clk),
    .reset (reset),
    .mdu   (mif)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        irq;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] rd;
    int          cyc;
  } vec_t;

  vec_t tbl[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [7:0] op, input logic [31:0] rs, input logic [31:0] rt,
                       input logic irq);
    mif.E_ALUop_i   = op;
    mif.E_rsValue_i = rs;
    mif.E_rtValue_i = rt;
    mif.IntReq      = irq;
  endtask

  // Called at posedge+2; counts sampled cycles with busy high, bounded.
  task automatic count_busy(output int cnt);
    cnt = 0;
    while (mif.mdu_busy_o === 1'b1 && cnt < 60) begin
      cnt++;
      @(posedge clk);
      #2;
    end
  endtask

  task automatic do_op(input logic [7:0] op, input logic [31:0] rs, input logic [31:0] rt,
                       input logic irq, input string tag, input logic [31:0] exp_rd,
                       output int cyc);
    logic exp_start;
    exp_start = (op inside {MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU}) && !irq;
    @(posedge clk);
    #1;
    drive(op, rs, rt, irq);
    #1;
    check({tag, " start"}, 32'(mif.mdu_start_o), 32'(exp_start));
    check({tag, " rd"}, mif.mdu_rd_o, exp_rd);
    @(posedge clk);
    #1;
    drive(NOP, 32'd0, 32'd0, 1'b0);
    #1;
    count_busy(cyc);
  endtask

  // Reference: architectural effect of one instruction, from plain 64-bit arithmetic.
  task automatic model_step(input logic [7:0] op, input logic [31:0] rs, input logic [31:0] rt,
                            input logic irq, output logic [31:0] exp_rd, output int exp_cyc);
    int sa, sb;
    longint a, b, q, r, p;
    longint unsigned ua, ub, uq, ur, up;
    exp_rd  = (op == MDU_MFHI) ? m_hi : (op == MDU_MFLO) ? m_lo : 32'd0;
    exp_cyc = 0;
    sa = rs; sb = rt; a = sa; b = sb;
    ua = rs; ub = rt;
    if (!irq) begin
      case (op)
        MDU_MULT:  begin p = a * b;   {m_hi, m_lo} = p;  exp_cyc = MULT_CYCLES; end
        MDU_MULTU: begin up = ua * ub; {m_hi, m_lo} = up; exp_cyc = MULT_CYCLES; end
        MDU_DIV: begin
          exp_cyc = DIV_CYCLES;
          if (rt != 0) begin q = a / b; r = a % b; m_lo = q[31:0]; m_hi = r[31:0]; end
        end
        MDU_DIVU: begin
          exp_cyc = DIV_CYCLES;
          if (rt != 0) begin uq = ua / ub; ur = ua % ub; m_lo = uq[31:0]; m_hi = ur[31:0]; end
        end
        MDU_MTHI: m_hi = rs;
        MDU_MTLO: m_lo = rs;
        default: ;
      endcase
    end
  endtask

  initial begin
    int cyc;
    logic [31:0] exp_rd;
    int exp_cyc;
    logic [7:0] ops[9];
    logic [7:0] op;
    logic [31:0] rs, rt;
    logic irq;

    tbl[0]  = '{MDU_MULT,  32'hFFFFFFFE, 32'd3,        1'b0, 32'hFFFFFFFF, 32'hFFFFFFFA, 32'h0, MULT_CYCLES};
    tbl[1]  = '{MDU_MULTU, 32'hFFFFFFFF, 32'd2,        1'b0, 32'h00000001, 32'hFFFFFFFE, 32'h0, MULT_CYCLES};
    tbl[2]  = '{MDU_MFHI,  32'h0,        32'h0,        1'b0, 32'h00000001, 32'hFFFFFFFE, 32'h1, 0};
    tbl[3]  = '{MDU_DIV,   32'hFFFFFFF9, 32'd2,        1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'h0, DIV_CYCLES};
    tbl[4]  = '{MDU_DIVU,  32'd7,        32'd0,        1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'h0, DIV_CYCLES};
    tbl[5]  = '{MDU_MTHI,  32'h12345678, 32'h0,        1'b0, 32'h12345678, 32'hFFFFFFFD, 32'h0, 0};
    tbl[6]  = '{MDU_MTHI,  32'hAAAAAAAA, 32'h0,        1'b1, 32'h12345678, 32'hFFFFFFFD, 32'h0, 0};
    tbl[7]  = '{MDU_MTLO,  32'hCAFEF00D, 32'h0,        1'b0, 32'h12345678, 32'hCAFEF00D, 32'h0, 0};
    tbl[8]  = '{MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h00000000, 32'h80000000, 32'h0, DIV_CYCLES};
    tbl[9]  = '{MDU_DIV,   32'd5,        32'd2,        1'b1, 32'h00000000, 32'h80000000, 32'h0, 0};
    tbl[10] = '{NOP,       32'd9,        32'd9,        1'b0, 32'h00000000, 32'h80000000, 32'h0, 0};
    tbl[11] = '{MDU_MFLO,  32'h0,        32'h0,        1'b0, 32'h00000000, 32'h80000000, 32'h80000000, 0};
    tbl[12] = '{MDU_DIV,   32'd7,        32'hFFFFFFFE, 1'b0, 32'h00000001, 32'hFFFFFFFD, 32'h0, DIV_CYCLES};
    tbl[13] = '{MDU_MULT,  32'h80000000, 32'h80000000, 1'b0, 32'h40000000, 32'h00000000, 32'h0, MULT_CYCLES};

    drive(NOP, 32'd0, 32'd0, 1'b0);
    #1;
    check("reset busy", 32'(mif.mdu_busy_o), 32'd0);
    check("reset hi", mif.mdu_hi_o, 32'd0);
    check("reset lo", mif.mdu_lo_o, 32'd0);
    check("reset start", 32'(mif.mdu_start_o), 32'd0);
    #11;
    reset = 1'b1;

    for (int i = 0; i < 14; i++) begin
      string tag;
      tag = $sformatf("tbl%0d", i);
      do_op(tbl[i].op, tbl[i].rs, tbl[i].rt, tbl[i].irq, tag, tbl[i].rd, cyc);
      check({tag, " cycles"}, 32'(cyc), 32'(tbl[i].cyc));
      check({tag, " hi"}, mif.mdu_hi_o, tbl[i].hi);
      check({tag, " lo"}, mif.mdu_lo_o, tbl[i].lo);
    end
    m_hi = 32'h40000000;
    m_lo = 32'h00000000;

    // IntReq and conflicting MDU ops during RUN must neither abort nor disturb the op.
    @(posedge clk);
    #1;
    drive(MDU_MULTU, 32'h00010000, 32'h00010000, 1'b0);
    #1;
    check("run_irq start", 32'(mif.mdu_start_o), 32'd1);
    @(posedge clk);
    #2;
    cyc = 0;
    while (mif.mdu_busy_o === 1'b1 && cyc < 60) begin
      cyc++;
      case (cyc % 4)
        0: drive(MDU_MTHI, 32'hDEADBEEF, 32'd0, 1'b0);
        1: drive(MDU_DIV, 32'd100, 32'd3, 1'b1);
        2: drive(MDU_MTLO, 32'hBEEFBEEF, 32'd0, 1'b1);
        default: drive(MDU_MULT, 32'd3, 32'd3, 1'b0);
      endcase
      @(posedge clk);
      #2;
    end
    drive(NOP, 32'd0, 32'd0, 1'b0);
    check("run_irq cycles", 32'(cyc), 32'(MULT_CYCLES));
    check("run_irq hi", mif.mdu_hi_o, 32'h00000001);
    check("run_irq lo", mif.mdu_lo_o, 32'h00000000);
    m_hi = 32'h00000001;
    m_lo = 32'h00000000;

    ops = '{MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_MTHI, MDU_MTLO, MDU_MFHI, MDU_MFLO, NOP};
    for (int n = 0; n < 40; n++) begin
      string tag;
      tag = $sformatf("rnd%0d", n);
      op  = ops[$urandom_range(0, 8)];
      rs  = $urandom;
      rt  = $urandom;
      if ($urandom_range(0, 7) == 0) rt = 32'd0;
      if ($urandom_range(0, 9) == 0) begin rs = 32'h80000000; rt = 32'hFFFFFFFF; end
      if ($urandom_range(0, 3) == 0) rt = rt >> $urandom_range(1, 31);
      irq = ($urandom_range(0, 7) == 0);
      model_step(op, rs, rt, irq, exp_rd, exp_cyc);
      do_op(op, rs, rt, irq, tag, exp_rd, cyc);
      check({tag, " cycles"}, 32'(cyc), 32'(exp_cyc));
      check({tag, " hi"}, mif.mdu_hi_o, m_hi);
      check({tag, " lo"}, mif.mdu_lo_o, m_lo);
    end

    // Asynchronous reset in the third cycle of a divide: cleared at once, no late commit.
    @(posedge clk);
    #1;
    drive(MDU_DIV, 32'd100, 32'd7, 1'b0);
    @(posedge clk);
    #1;
    drive(NOP, 32'd0, 32'd0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("arst busy", 32'(mif.mdu_busy_o), 32'd0);
    check("arst hi", mif.mdu_hi_o, 32'd0);
    check("arst lo", mif.mdu_lo_o, 32'd0);
    #3;
    reset = 1'b1;
    repeat (15) @(posedge clk);
    #2;
    check("arst late busy", 32'(mif.mdu_busy_o), 32'd0);
    check("arst late hi", mif.mdu_hi_o, 32'd0);
    check("arst late lo", mif.mdu_lo_o, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
